// File: rtl/mem_ctrl_arb_pkg.sv
// Shared types and helpers for the multi-channel memory controller.
package mem_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam int unsigned WaitCntW = 4;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module mem_ctrl_arb_rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  int unsigned         sel;

  // Rotate so that the channel at ptr lands on bit 0.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_CH-1:0];

  always_comb begin
    sel       = 0;
    gnt_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!gnt_valid && req_rot[i]) begin
        gnt_valid = 1'b1;
        sel       = i;
      end
    end
    gnt_idx = IDX_W'((32'(ptr) + sel) % NUM_CH);
    gnt     = gnt_valid ? (NUM_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Single-port RAM shared by NUM_CH requesters through a round-robin arbiter,
// with configurable access latency and out-of-range error reporting.
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic                     busy
);

  localparam int unsigned          IdxW    = idx_width(NUM_CH);
  localparam int unsigned          RamAw   = idx_width(DEPTH);
  localparam logic [WaitCntW-1:0]  LastCnt = WaitCntW'(WAIT_STATES);
  localparam logic [IdxW-1:0]      LastCh  = IdxW'(NUM_CH - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
  end

  logic [NUM_CH-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              acc_we;

  state_e              state_q;
  logic [WaitCntW-1:0] cnt_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     sel_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oor_q;
  logic [NUM_CH-1:0]   ch_ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                busy_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              last_access;
  logic [RamAw-1:0]  ram_idx;

  mem_ctrl_arb_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IdxW)
  ) u_rr_arbiter (
    .req       (ch_req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign acc_we      = |(ch_we & gnt);
  assign in_range    = (32'(addr_q) < DEPTH);
  assign ram_idx     = addr_q[RamAw-1:0];
  assign last_access = (state_q == StAccess) && (cnt_q == LastCnt);

  // Contents survive reset; an aborted transaction never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (last_access && we_q && in_range) begin
      mem[ram_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      ch_ready_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ch_ready_q <= '0;
      err_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            sel_q   <= gnt_idx;
            we_q    <= acc_we;
            addr_q  <= addr_arr[gnt_idx];
            wdata_q <= wdata_arr[gnt_idx];
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == LastCnt) begin
            oor_q <= !in_range;
            if (!we_q) begin
              rdata_q <= in_range ? mem[ram_idx] : '0;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + WaitCntW'(1);
          end
        end
        StResp: begin
          ch_ready_q <= NUM_CH'(1) << sel_q;
          err_q      <= oor_q;
          ptr_q      <= (sel_q == LastCh) ? '0 : sel_q + IdxW'(1);
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_ready = ch_ready_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Bench for mem_ctrl_arb: per-channel op queues feed the DUT, a transaction-level
// model predicts grant order, completion timing, read data and error pulses.
module tb_mem_ctrl_arb;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned NCH   = 3;
  localparam int unsigned WS    = 1;
  localparam int          FDEP  = 64;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    ch_req, ch_we, ch_ready;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     rdata;
  logic              err, busy;

  always #5 clk = ~clk;

  mem_ctrl_arb #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .NUM_CH      (NCH),
    .WAIT_STATES (WS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_we    (ch_we),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_ready (ch_ready),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t fifo [NCH][FDEP];
  int  head [NCH];
  int  tail [NCH];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [DW-1:0]  mmem   [256];
  bit             mknown [256];
  bit             m_active;
  int             m_ch, m_acc, m_ptr;
  op_t            m_op;
  bit             m_oor;
  logic [DW-1:0]  exp_rdata;
  bit             rd_known;
  logic [NCH-1:0] exp_ready;
  bit             exp_err;
  bit             rand_on, in_reset;

  int            served_ch  [$];
  logic [DW-1:0] served_rd  [$];
  bit            served_err [$];
  int            last_ready_cyc, last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] r, input int ptr);
    for (int o = 0; o < NCH; o++) begin
      int c;
      c = (ptr + o) % NCH;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic bit any_pending();
    for (int c = 0; c < NCH; c++) if (head[c] != tail[c]) return 1'b1;
    return m_active;
  endfunction

  task automatic push(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fifo[c][tail[c] % FDEP] = '{we: we, addr: a, wdata: d};
    tail[c]++;
  endtask

  task automatic clear_log();
    served_ch.delete();
    served_rd.delete();
    served_err.delete();
  endtask

  // Transaction timing: accept at edge k, commit at k+WS+1, ready pulse after k+WS+2.
  task automatic model_edge();
    exp_ready = '0;
    exp_err   = 1'b0;
    if (!reset) return;
    if (m_active) begin
      if (cyc == m_acc + WS + 1) begin
        m_oor = (int'(m_op.addr) >= DEPTH);
        if (m_oor) begin
          if (!m_op.we) begin
            exp_rdata = '0;
            rd_known  = 1'b1;
          end
        end else if (m_op.we) begin
          mmem[m_op.addr]   = m_op.wdata;
          mknown[m_op.addr] = 1'b1;
        end else begin
          exp_rdata = mmem[m_op.addr];
          rd_known  = mknown[m_op.addr];
        end
      end else if (cyc == m_acc + WS + 2) begin
        exp_ready[m_ch] = 1'b1;
        exp_err         = m_oor;
        m_ptr           = (m_ch + 1) % NCH;
        m_active        = 1'b0;
      end
    end else if (ch_req != '0) begin
      m_ch     = pick(ch_req, m_ptr);
      m_op     = fifo[m_ch][head[m_ch] % FDEP];
      m_acc    = cyc;
      last_acc = cyc;
      m_active = 1'b1;
    end
  endtask

  task automatic sample_check();
    check_eq("ch_ready", 32'(ch_ready), 32'(exp_ready));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("busy", 32'(busy), 32'(m_active));
    if (rd_known) check_eq("rdata", 32'(rdata), 32'(exp_rdata));
    if (ch_ready != '0) begin
      for (int c = 0; c < NCH; c++) if (ch_ready[c]) served_ch.push_back(c);
      served_rd.push_back(rdata);
      served_err.push_back(err);
      last_ready_cyc = cyc;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      if (exp_ready[c] && head[c] != tail[c]) head[c]++;
      if (rand_on && head[c] == tail[c] && $urandom_range(0, 2) == 0)
        push(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom));
      if (in_reset) begin
        ch_req[c] = 1'($urandom_range(0, 1));
        ch_we[c]  = 1'($urandom_range(0, 1));
        ch_addr[c*AW +: AW]  = AW'($urandom);
        ch_wdata[c*DW +: DW] = DW'($urandom);
      end else if (head[c] != tail[c]) begin
        ch_req[c] = 1'b1;
        ch_we[c]  = fifo[c][head[c] % FDEP].we;
        ch_addr[c*AW +: AW]  = fifo[c][head[c] % FDEP].addr;
        ch_wdata[c*DW +: DW] = fifo[c][head[c] % FDEP].wdata;
      end else begin
        ch_req[c] = 1'b0;
        ch_we[c]  = 1'($urandom_range(0, 1));
        ch_addr[c*AW +: AW]  = AW'($urandom);
        ch_wdata[c*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    sample_check();
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (any_pending() && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_done", 32'(any_pending()), 32'd0);
  endtask

  // Asserted away from the edge; the DUT must clear its outputs without a clock.
  task automatic do_reset(input int n);
    reset     = 1'b0;
    in_reset  = 1'b1;
    m_active  = 1'b0;
    m_ptr     = 0;
    exp_rdata = '0;
    rd_known  = 1'b1;
    exp_ready = '0;
    exp_err   = 1'b0;
    for (int c = 0; c < NCH; c++) head[c] = tail[c];
    #1;
    sample_check();
    drive();
    repeat (n) tick();
    reset    = 1'b1;
    in_reset = 1'b0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
    for (int a = 0; a < 256; a++) mknown[a] = 1'b0;
    rand_on = 1'b0;
    ch_req  = '0;
    ch_we   = '0;
    ch_addr = '0;
    ch_wdata = '0;

    // Reset held with random channel activity
    do_reset(5);

    // Preload every implemented word so later reads have known contents
    for (int a = 0; a < int'(DEPTH); a++) begin
      push(a % NCH, 1'b1, AW'(a), DW'($urandom));
      drain(20);
    end

    // Write then read on channel 0
    clear_log();
    push(0, 1'b1, 8'h01, 8'h16);
    drain(20);
    push(0, 1'b0, 8'h01, 8'h00);
    drain(20);
    check_eq("rd_latency", 32'(last_ready_cyc - last_acc), WS + 2);
    check_eq("rd_0x01", 32'(served_rd[1]), 32'h16);
    check_eq("rd_0x01_err", 32'(served_err[1]), 32'd0);

    // Simultaneous writes from ch0 and ch1
    do_reset(2);
    clear_log();
    push(0, 1'b1, 8'h02, 8'hAA);
    push(1, 1'b1, 8'h03, 8'h55);
    drain(30);
    check_eq("sim_first", 32'(served_ch[0]), 32'd0);
    check_eq("sim_second", 32'(served_ch[1]), 32'd1);
    push(0, 1'b0, 8'h02, 8'h00);
    push(1, 1'b0, 8'h03, 8'h00);
    drain(30);
    check_eq("rb_0x02", 32'(served_rd[2]), 32'hAA);
    check_eq("rb_0x03", 32'(served_rd[3]), 32'h55);

    // Continuous reads on ch0 and ch1 must alternate
    do_reset(2);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00);
      push(1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00);
    end
    drain(60);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_order%0d", i), 32'(served_ch[i]), 32'(i % 2));

    // Out-of-range read and write on ch1
    clear_log();
    push(1, 1'b0, 8'd250, 8'h00);
    drain(20);
    check_eq("oor_rd_ch", 32'(served_ch[0]), 32'd1);
    check_eq("oor_rd_err", 32'(served_err[0]), 32'd1);
    check_eq("oor_rd_data", 32'(served_rd[0]), 32'd0);
    push(1, 1'b1, 8'd250, 8'h3C);
    drain(20);
    check_eq("oor_wr_err", 32'(served_err[1]), 32'd1);
    for (int a = 0; a < int'(DEPTH); a++) begin
      push(1, 1'b0, AW'(a), 8'h00);
      drain(20);
    end

    // Reset during ACCESS aborts an uncommitted write
    clear_log();
    push(0, 1'b1, 8'h05, 8'h11);
    drain(20);
    push(0, 1'b1, 8'h05, 8'h77);
    begin
      int n;
      n = 0;
      while (!m_active && n < 20) begin
        tick();
        n++;
      end
    end
    check_eq("abort_accepted", 32'(m_active), 32'd1);
    do_reset(3);
    clear_log();
    push(0, 1'b0, 8'h05, 8'h00);
    drain(20);
    check_eq("abort_rb_0x05", 32'(served_rd[0]), 32'h11);

    // Random traffic on all channels
    rand_on = 1'b1;
    repeat (400) tick();
    rand_on = 1'b0;
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
